alsu_req_sequencer: RTL and testbench

//  Shares one ALSU between two requesters. Accepts packed commands on a valid/ready handshake
//  and arbitrates (round-robin or fixed). Drives ALSU inputs for exactly one operation at a time,

---
 rtl/alsu_req_sequencer_pkg.sv | 44 ++++
 rtl/alsu_req_sequencer_rr_arbiter_2.sv | 41 ++++
 rtl/alsu_req_sequencer.sv | 129 ++++++++++++
 tb/tb_alsu_req_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alsu_req_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alsu_req_sequencer_pkg
//  Purpose  : Command layout, opcodes and FSM states shared by the ALSU
//             request sequencer and its arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package alsu_req_sequencer_pkg;

  localparam int CMD_W  = 16;
  localparam int CTRL_W = 7;

  typedef enum logic [2:0] {
    OP_AND      = 3'd0,
    OP_XOR      = 3'd1,
    OP_ADD      = 3'd2,
    OP_MULT     = 3'd3,
    OP_SHIFT    = 3'd4,
    OP_ROTATE   = 3'd5,
    OP_INVALID6 = 3'd6,
    OP_INVALID7 = 3'd7
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_CAPTURE = 2'd3
  } state_e;

  // ctrl = {cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B}
  typedef struct packed {
    opcode_e           opcode;
    logic [2:0]        a;
    logic [2:0]        b;
    logic [CTRL_W-1:0] ctrl;
  } cmd_t;

  function automatic logic op_is_legal(input opcode_e op);
    return (op != OP_INVALID6) && (op != OP_INVALID7);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alsu_req_sequencer_rr_arbiter_2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter_2
//  Purpose  : Two-way arbiter, round-robin or fixed-priority, one-hot grant.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter_2 #(
  parameter string ARB_MODE = "RR"
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid_i,
  input  logic       accept_i,
  output logic [1:0] grant_o
);

  localparam bit FIXED0 = (ARB_MODE == "FIXED0");

  // Index of the requester served last; reset to 1 so requester 0 goes first.
  logic last_q;

  always_comb begin
    grant_o = 2'b00;
    case (valid_i)
      2'b01:   grant_o = 2'b01;
      2'b10:   grant_o = 2'b10;
      2'b11:   grant_o = (FIXED0 || last_q) ? 2'b01 : 2'b10;
      default: grant_o = 2'b00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_q <= 1'b1;
    end else if (accept_i) begin
      last_q <= grant_o[1];
    end
  end

endmodule
`default_nettype wire

// File: rtl/alsu_req_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alsu_req_sequencer
//  Purpose  : Shares one ALSU between two requesters, one operation at a time,
//             returning id-tagged results; opcodes 6/7 are rejected locally.
//  Revision : 1.0  initial release
// ============================================================================
module alsu_req_sequencer
  import alsu_req_sequencer_pkg::*;
#(
  parameter int    ALSU_LAT = 2,
  parameter string ARB_MODE = "RR"
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  input  logic [CMD_W-1:0]  req0_cmd,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [CMD_W-1:0]  req1_cmd,
  output logic              req1_ready,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [5:0]        rsp_data,
  output logic              rsp_err,
  output logic              busy,
  output logic [2:0]        alsu_A,
  output logic [2:0]        alsu_B,
  output logic [2:0]        alsu_opcode,
  output logic [CTRL_W-1:0] alsu_ctrl,
  input  logic [5:0]        alsu_out
);

  state_e     state_q;
  cmd_t       cmd_q;
  logic       id_q;
  logic [2:0] cnt_q;
  logic       rsp_valid_q;
  logic       rsp_id_q;
  logic       rsp_err_q;
  logic [5:0] rsp_data_q;

  logic [1:0] grant_d;
  logic       accept_d;
  logic       win_id_d;
  cmd_t       win_cmd_d;

  rr_arbiter_2 #(
    .ARB_MODE (ARB_MODE)
  ) u_arb (
    .clk      (clk),
    .rst      (rst),
    .valid_i  ({req1_valid, req0_valid}),
    .accept_i (accept_d),
    .grant_o  (grant_d)
  );

  assign accept_d   = (state_q == ST_IDLE) && (req0_valid || req1_valid);
  assign req0_ready = accept_d && grant_d[0];
  assign req1_ready = accept_d && grant_d[1];
  assign win_id_d   = grant_d[1];
  assign win_cmd_d  = grant_d[1] ? cmd_t'(req1_cmd) : cmd_t'(req0_cmd);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      id_q        <= 1'b0;
      cnt_q       <= 3'd0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 6'd0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (accept_d) begin
            cmd_q <= win_cmd_d;
            id_q  <= win_id_d;
            if (op_is_legal(win_cmd_d.opcode)) begin
              state_q <= ST_ISSUE;
            end else begin
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= 6'd0;
              rsp_id_q    <= win_id_d;
            end
          end
        end
        ST_ISSUE: begin
          cnt_q   <= 3'(ALSU_LAT - 1);
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          // The response is registered on entry to CAPTURE so it is visible there.
          if (cnt_q == 3'd0) begin
            state_q     <= ST_CAPTURE;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= alsu_out;
            rsp_id_q    <= id_q;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ST_CAPTURE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign alsu_opcode = busy ? cmd_q.opcode : 3'd0;
  assign alsu_A      = busy ? cmd_q.a      : 3'd0;
  assign alsu_B      = busy ? cmd_q.b      : 3'd0;
  assign alsu_ctrl   = busy ? cmd_q.ctrl   : 7'd0;

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;

endmodule
`default_nettype wire

// File: tb/tb_alsu_req_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alsu_req_sequencer
//  Purpose  : Directed bench for the ALSU request sequencer with a two-stage
//             ALSU model (RR instance) and a FIXED0 instance for arbitration.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alsu_req_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // RR instance
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic [15:0] req0_cmd = '0, req1_cmd = '0;
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_id, rsp_err, busy;
  logic [5:0]  rsp_data;
  logic [2:0]  alsu_A, alsu_B, alsu_opcode;
  logic [6:0]  alsu_ctrl;
  logic [5:0]  alsu_out;

  // FIXED0 instance
  logic        f_req0_valid = 1'b0, f_req1_valid = 1'b0;
  logic [15:0] f_req0_cmd = '0, f_req1_cmd = '0;
  logic        f_req0_ready, f_req1_ready;
  logic        f_rsp_valid, f_rsp_id, f_rsp_err, f_busy;
  logic [5:0]  f_rsp_data;
  logic [2:0]  f_alsu_A, f_alsu_B, f_alsu_opcode;
  logic [6:0]  f_alsu_ctrl;
  logic [5:0]  f_alsu_out = 6'd0;

  alsu_req_sequencer #(.ALSU_LAT(2), .ARB_MODE("RR")) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_cmd(req0_cmd), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_cmd(req1_cmd), .req1_ready(req1_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .alsu_A(alsu_A), .alsu_B(alsu_B), .alsu_opcode(alsu_opcode),
    .alsu_ctrl(alsu_ctrl), .alsu_out(alsu_out)
  );

  alsu_req_sequencer #(.ALSU_LAT(2), .ARB_MODE("FIXED0")) u_fix (
    .clk(clk), .rst(rst),
    .req0_valid(f_req0_valid), .req0_cmd(f_req0_cmd), .req0_ready(f_req0_ready),
    .req1_valid(f_req1_valid), .req1_cmd(f_req1_cmd), .req1_ready(f_req1_ready),
    .rsp_valid(f_rsp_valid), .rsp_id(f_rsp_id), .rsp_data(f_rsp_data), .rsp_err(f_rsp_err),
    .busy(f_busy), .alsu_A(f_alsu_A), .alsu_B(f_alsu_B), .alsu_opcode(f_alsu_opcode),
    .alsu_ctrl(f_alsu_ctrl), .alsu_out(f_alsu_out)
  );

  // ALSU model: input register then output register (latency 2).
  logic [2:0] s_op, s_a, s_b;
  logic [6:0] s_ctrl;

  function automatic logic [5:0] alsu_f(input logic [2:0] op, input logic [2:0] a,
                                        input logic [2:0] b, input logic [6:0] ctrl);
    if (ctrl[1]) return {3'd0, a};
    if (ctrl[0]) return {3'd0, b};
    case (op)
      3'd0:    return ctrl[3] ? {5'd0, &a} : (ctrl[2] ? {5'd0, &b} : {3'd0, a & b});
      3'd1:    return ctrl[3] ? {5'd0, ^a} : (ctrl[2] ? {5'd0, ^b} : {3'd0, a ^ b});
      3'd2:    return {3'd0, a} + {3'd0, b} + {5'd0, ctrl[6]};
      3'd3:    return {3'd0, a} * {3'd0, b};
      default: return 6'd0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      s_op <= '0; s_a <= '0; s_b <= '0; s_ctrl <= '0; alsu_out <= '0;
    end else begin
      s_op <= alsu_opcode; s_a <= alsu_A; s_b <= alsu_B; s_ctrl <= alsu_ctrl;
      alsu_out <= alsu_f(s_op, s_a, s_b, s_ctrl);
    end
  end

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [2:0] a,
                                     input logic [2:0] b, input logic [6:0] ctrl);
    return {op, a, b, ctrl};
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; f_req0_valid = 1'b0; f_req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 || rsp_id !== 1'b0) begin
      errors++; $display("FAIL reset_rsp: got v=%0b e=%0b id=%0b expected 0", rsp_valid, rsp_err, rsp_id); end
    checks++; if (rsp_data !== 6'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", rsp_data); end
    checks++; if ({alsu_A, alsu_B, alsu_opcode, alsu_ctrl} !== 16'd0) begin
      errors++; $display("FAIL reset_alsu: got %h expected 0", {alsu_A, alsu_B, alsu_opcode, alsu_ctrl}); end
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %0b%0b expected 00", req1_ready, req0_ready); end
  endtask

  // Single command on req0, checking latency, drive and result.
  task automatic test_single(input logic [2:0] op, input logic [2:0] a, input logic [2:0] b,
                             input logic [5:0] exp_data);
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_cmd = mk(op, a, b, 7'd0);
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL single_ready: got %0b%0b expected 01", req1_ready, req0_ready); end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      if (k <= 4) begin
        checks++; if (busy !== 1'b1 || alsu_opcode !== op || alsu_A !== a || alsu_B !== b) begin
          errors++; $display("FAIL single_drive k=%0d: got busy=%0b op=%0d A=%0d B=%0d expected 1 %0d %0d %0d",
                             k, busy, alsu_opcode, alsu_A, alsu_B, op, a, b); end
      end
      checks++; if (rsp_valid !== (k == 4)) begin
        errors++; $display("FAIL single_rsp_valid k=%0d: got %0b expected %0b", k, rsp_valid, (k == 4)); end
      if (k == 4) begin
        checks++; if (rsp_data !== exp_data || rsp_id !== 1'b0 || rsp_err !== 1'b0) begin
          errors++; $display("FAIL single_rsp: got data=%0d id=%0b err=%0b expected %0d 0 0",
                             rsp_data, rsp_id, rsp_err, exp_data); end
      end
      if (k == 5) begin
        checks++; if (busy !== 1'b0 || alsu_opcode !== 3'd0) begin
          errors++; $display("FAIL single_idle: got busy=%0b op=%0d expected 0 0", busy, alsu_opcode); end
      end
    end
  endtask

  task automatic test_both_after_reset();
    int a0 = -1, a1 = -1, nr = 0;
    int rt[2]; logic rid[2]; logic [5:0] rd[2];
    rt = '{-1, -1}; rid = '{1'b0, 1'b0}; rd = '{6'd0, 6'd0};
    do_reset();
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_cmd = mk(3'd0, 3'd5, 3'd7, 7'd0);
    req1_valid = 1'b1; req1_cmd = mk(3'd1, 3'd5, 3'd7, 7'd0);
    for (int cyc = 0; cyc < 16; cyc++) begin
      logic d0, d1;
      @(negedge clk);
      d0 = req0_ready; d1 = req1_ready;
      if (d0) a0 = cyc;
      if (d1) a1 = cyc;
      if (rsp_valid) begin
        if (nr < 2) begin rt[nr] = cyc; rid[nr] = rsp_id; rd[nr] = rsp_data; end
        nr++;
      end
      @(posedge clk); #1;
      if (d0) req0_valid = 1'b0;
      if (d1) req1_valid = 1'b0;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++; if (a0 !== 0 || a1 !== 5) begin
      errors++; $display("FAIL both_accept: got req0@%0d req1@%0d expected 0 5", a0, a1); end
    checks++; if (nr !== 2) begin errors++; $display("FAIL both_count: got %0d expected 2", nr); end
    checks++; if (rid[0] !== 1'b0 || rd[0] !== 6'd5) begin
      errors++; $display("FAIL both_first: got id=%0b data=%0d expected 0 5", rid[0], rd[0]); end
    checks++; if (rid[1] !== 1'b1 || rd[1] !== 6'd2) begin
      errors++; $display("FAIL both_second: got id=%0b data=%0d expected 1 2", rid[1], rd[1]); end
    checks++; if (rt[0] !== 4 || rt[1] - rt[0] !== 5) begin
      errors++; $display("FAIL both_timing: got %0d,%0d expected 4,9", rt[0], rt[1]); end
  endtask

  task automatic test_reject();
    @(posedge clk); #1;
    req1_valid = 1'b1; req1_cmd = mk(3'd7, 3'd3, 3'd3, 7'h7f);
    @(negedge clk);
    checks++; if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
      errors++; $display("FAIL reject_ready: got %0b%0b expected 10", req1_ready, req0_ready); end
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 6'd0 || rsp_id !== 1'b1) begin
      errors++; $display("FAIL reject_rsp: got v=%0b e=%0b d=%0d id=%0b expected 1 1 0 1",
                         rsp_valid, rsp_err, rsp_data, rsp_id); end
    checks++; if ({alsu_A, alsu_B, alsu_opcode, alsu_ctrl} !== 16'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL reject_alsu: got %h busy=%0b expected 0 0",
                         {alsu_A, alsu_B, alsu_opcode, alsu_ctrl}, busy); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reject_pulse: got %0b expected 0", rsp_valid); end
  endtask

  task automatic test_rr_alternate();
    int na = 0, nr = 0, bad_order = 0, bad_rsp = 0, dbl = 0;
    logic prev = 1'b0;
    do_reset();
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_cmd = mk(3'd2, 3'd1, 3'd2, 7'd0);
    req1_valid = 1'b1; req1_cmd = mk(3'd2, 3'd3, 3'd4, 7'd0);
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        if (req1_ready !== logic'(na % 2)) bad_order++;
        na++;
      end
      if (rsp_valid) begin
        if (rsp_id !== logic'(nr % 2) || rsp_data !== (rsp_id ? 6'd7 : 6'd3)) bad_rsp++;
        nr++;
      end
      if (rsp_valid && prev) dbl++;
      prev = rsp_valid;
      @(posedge clk); #1;
      if (na >= 6) begin req0_valid = 1'b0; req1_valid = 1'b0; end
    end
    checks++; if (na !== 6) begin errors++; $display("FAIL rr_accepts: got %0d expected 6", na); end
    checks++; if (bad_order !== 0) begin errors++; $display("FAIL rr_order: got %0d out-of-order grants expected 0", bad_order); end
    checks++; if (nr !== 6 || bad_rsp !== 0) begin
      errors++; $display("FAIL rr_rsp: got %0d rsps %0d bad expected 6 0", nr, bad_rsp); end
    checks++; if (dbl !== 0) begin errors++; $display("FAIL rr_double_valid: got %0d expected 0", dbl); end
  endtask

  task automatic test_fixed0();
    int na = 0, early1 = 0, nr = 0, bad_id = 0;
    logic got1 = 1'b0;
    do_reset();
    @(posedge clk); #1;
    f_req0_valid = 1'b1; f_req0_cmd = mk(3'd2, 3'd1, 3'd2, 7'd0);
    f_req1_valid = 1'b1; f_req1_cmd = mk(3'd2, 3'd3, 3'd4, 7'd0);
    for (int cyc = 0; cyc < 45; cyc++) begin
      logic d1;
      @(negedge clk);
      d1 = f_req1_ready;
      if (f_req0_ready) na++;
      if (d1) begin
        if (na < 6) early1++;
        got1 = 1'b1;
      end
      if (f_rsp_valid) begin
        if (f_rsp_err !== 1'b0 || f_rsp_id !== (nr >= 6)) bad_id++;
        nr++;
      end
      @(posedge clk); #1;
      if (na >= 6) f_req0_valid = 1'b0;
      if (d1) f_req1_valid = 1'b0;
    end
    f_req0_valid = 1'b0; f_req1_valid = 1'b0;
    checks++; if (na !== 6) begin errors++; $display("FAIL fixed_req0_accepts: got %0d expected 6", na); end
    checks++; if (early1 !== 0) begin errors++; $display("FAIL fixed_req1_early: got %0d expected 0", early1); end
    checks++; if (got1 !== 1'b1) begin errors++; $display("FAIL fixed_req1_served: got %0b expected 1", got1); end
    checks++; if (nr !== 7 || bad_id !== 0) begin
      errors++; $display("FAIL fixed_rsp: got %0d rsps %0d bad expected 7 0", nr, bad_id); end
  endtask

  task automatic test_reset_mid();
    int stray = 0;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_cmd = mk(3'd3, 3'd5, 3'd7, 7'd0);
    @(negedge clk);
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL mid_ready: got %0b expected 1", req0_ready); end
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (busy !== 1'b1 || alsu_opcode !== 3'd3) begin
      errors++; $display("FAIL mid_wait: got busy=%0b op=%0d expected 1 3", busy, alsu_opcode); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || alsu_opcode !== 3'd0) begin
      errors++; $display("FAIL mid_after_rst: got busy=%0b v=%0b op=%0d expected 0 0 0", busy, rsp_valid, alsu_opcode); end
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL mid_stray_rsp: got %0d expected 0", stray); end
    test_single(3'd3, 3'd5, 3'd7, 6'd35);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single(3'd2, 3'd5, 3'd7, 6'd12);
    test_both_after_reset();
    test_reject();
    test_rr_alternate();
    test_fixed0();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
